// File: rtl/door_interlock_arbiter_if.sv
// Signal bundle between the vestibule arbiter and the two door drives / sensors.
interface door_interlock_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic       presence_a;
  logic       presence_b;
  logic       opened_a;
  logic       closed_a;
  logic       opened_b;
  logic       closed_b;
  logic       fault_clr;
  logic       open_a;
  logic       close_a;
  logic       open_b;
  logic       close_b;
  logic [1:0] grant;
  logic       busy;
  logic       fault;

  modport master (
    output req_a, req_b, presence_a, presence_b,
    output opened_a, closed_a, opened_b, closed_b, fault_clr,
    input  open_a, close_a, open_b, close_b, grant, busy, fault
  );

  modport slave (
    input  req_a, req_b, presence_a, presence_b,
    input  opened_a, closed_a, opened_b, closed_b, fault_clr,
    output open_a, close_a, open_b, close_b, grant, busy, fault
  );
endinterface

// File: rtl/door_interlock_arbiter.sv
// Airlock scheduler: grants the shared vestibule to one sliding door at a time and
// sequences it through open / hold / close / settle with reopen, watchdog and latched fault.
module door_interlock_arbiter #(
  parameter int unsigned HOLD_CYCLES    = 15,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  door_interlock_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_HOLD,
    S_CLOSE,
    S_GAP,
    S_FAULT
  } state_t;

  state_t           r_state, w_state;
  logic             r_sel, w_sel;       // 0 = door A, 1 = door B
  logic             r_last, w_last;
  logic             r_pend_a, w_pend_a;
  logic             r_pend_b, w_pend_b;
  logic [CNT_W-1:0] r_cnt, w_cnt;       // hold / gap countdown
  logic [CNT_W-1:0] r_wd, w_wd;         // motion watchdog
  logic             r_open_a, w_open_a;
  logic             r_close_a, w_close_a;
  logic             r_open_b, w_open_b;
  logic             r_close_b, w_close_b;
  logic [1:0]       r_grant, w_grant;
  logic             r_busy, w_busy;
  logic             r_fault, w_fault;

  logic             w_req_sel, w_pres_sel, w_opened_sel, w_closed_sel;
  logic             w_abs_a, w_abs_b;
  logic [CNT_W-1:0] w_wd_inc;
  logic             w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_pend_a  <= 1'b0;
      r_pend_b  <= 1'b0;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_open_a  <= 1'b0;
      r_close_a <= 1'b0;
      r_open_b  <= 1'b0;
      r_close_b <= 1'b0;
      r_grant   <= 2'b00;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sel     <= w_sel;
      r_last    <= w_last;
      r_pend_a  <= w_pend_a;
      r_pend_b  <= w_pend_b;
      r_cnt     <= w_cnt;
      r_wd      <= w_wd;
      r_open_a  <= w_open_a;
      r_close_a <= w_close_a;
      r_open_b  <= w_open_b;
      r_close_b <= w_close_b;
      r_grant   <= w_grant;
      r_busy    <= w_busy;
      r_fault   <= w_fault;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_sel        = r_sel;
    w_last       = r_last;
    w_cnt        = r_cnt;
    w_wd         = r_wd;
    w_open_a     = 1'b0;
    w_close_a    = 1'b0;
    w_open_b     = 1'b0;
    w_close_b    = 1'b0;
    w_grant      = 2'b00;
    w_busy       = 1'b0;
    w_fault      = 1'b0;

    w_req_sel    = r_sel ? bus.req_b    : bus.req_a;
    w_pres_sel   = r_sel ? bus.presence_b : bus.presence_a;
    w_opened_sel = r_sel ? bus.opened_b : bus.opened_a;
    w_closed_sel = r_sel ? bus.closed_b : bus.closed_a;

    // A request from the door already holding the vestibule is absorbed, not queued
    w_abs_a      = bus.req_a && (r_grant == 2'b01);
    w_abs_b      = bus.req_b && (r_grant == 2'b10);
    w_pend_a     = r_pend_a || (bus.req_a && !w_abs_a);
    w_pend_b     = r_pend_b || (bus.req_b && !w_abs_b);

    w_wd_inc     = (r_wd == WD_MAX) ? r_wd : r_wd + CNT_ONE;
    w_timeout    = (w_wd_inc == WD_MAX);

    case (r_state)
      S_IDLE: begin
        if (bus.closed_a && bus.closed_b && (w_pend_a || w_pend_b)) begin
          w_state = S_OPEN;
          w_sel   = (w_pend_a && w_pend_b) ? !r_last : w_pend_b;
          w_wd    = CNT_ZERO;
        end
      end
      S_OPEN: begin
        if (w_opened_sel) begin
          w_state = S_HOLD;
          w_cnt   = HOLD_LOAD;
        end else begin
          w_wd = w_wd_inc;
          if (w_timeout) w_state = S_FAULT;
        end
      end
      S_HOLD: begin
        if (w_pres_sel) begin
          w_cnt = HOLD_LOAD;
        end else if (r_cnt == CNT_ZERO) begin
          w_state = S_CLOSE;
          w_wd    = CNT_ZERO;
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end
      S_CLOSE: begin
        // Someone in the threshold beats the closed switch: reopen
        if (w_pres_sel || w_req_sel) begin
          w_state = S_OPEN;
          w_wd    = CNT_ZERO;
        end else if (w_closed_sel) begin
          w_state = S_GAP;
          w_cnt   = GAP_LOAD;
          w_last  = r_sel;
        end else begin
          w_wd = w_wd_inc;
          if (w_timeout) w_state = S_FAULT;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_ZERO) w_state = S_IDLE;
        else                   w_cnt   = r_cnt - CNT_ONE;
      end
      S_FAULT: begin
        if (bus.fault_clr) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    if ((w_state == S_OPEN) && (r_state != S_OPEN)) begin
      if (w_sel) w_pend_b = 1'b0;
      else       w_pend_a = 1'b0;
    end

    // Registered outputs follow the state being entered
    w_open_a  = (w_state == S_OPEN)  && !w_sel;
    w_open_b  = (w_state == S_OPEN)  &&  w_sel;
    w_close_a = (w_state == S_CLOSE) && !w_sel;
    w_close_b = (w_state == S_CLOSE) &&  w_sel;
    if (w_state inside {S_OPEN, S_HOLD, S_CLOSE}) w_grant = w_sel ? 2'b10 : 2'b01;
    w_busy    = (w_state != S_IDLE);
    w_fault   = (w_state == S_FAULT);
  end

  assign bus.open_a  = r_open_a;
  assign bus.close_a = r_close_a;
  assign bus.open_b  = r_open_b;
  assign bus.close_b = r_close_b;
  assign bus.grant   = r_grant;
  assign bus.busy    = r_busy;
  assign bus.fault   = r_fault;

endmodule

// File: tb/tb_door_interlock_arbiter.sv
// Directed bench for door_interlock_arbiter: vector tables for whole door cycles plus
// hand sequences for hold reload, reopen, async reset and watchdog fault.
module tb_door_interlock_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  door_interlock_arbiter_if dif();

  door_interlock_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  // in : {req_a req_b}{pres_a pres_b}{opened_a closed_a opened_b closed_b}{fault_clr}
  // exp: {open_a close_a open_b close_b}{grant}{busy}{fault}
  typedef struct {
    int         rep;
    logic [8:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t t_single[9];
  vec_t t_tie[17];

  function automatic logic [7:0] outs();
    return {dif.open_a, dif.close_a, dif.open_b, dif.close_b, dif.grant, dif.busy, dif.fault};
  endfunction

  task automatic drive(input logic [8:0] v);
    {dif.req_a, dif.req_b, dif.presence_a, dif.presence_b,
     dif.opened_a, dif.closed_a, dif.opened_b, dif.closed_b, dif.fault_clr} = v;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = outs();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b  [open_a close_a open_b close_b grant busy fault]",
               name, got, exp);
    end
  endtask

  task automatic do_reset();
    drive(9'b00_00_0101_0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 8'b0000_00_0_0);
    rst = 1'b0;
  endtask

  // Interlock invariants on every cycle
  always @(negedge clk) begin
    n_checks++;
    if (($countones({dif.open_a, dif.close_a, dif.open_b, dif.close_b}) > 1) ||
        ((dif.grant == 2'b01) && (dif.open_b || dif.close_b)) ||
        ((dif.grant == 2'b10) && (dif.open_a || dif.close_a))) begin
      n_errors++;
      $display("FAIL interlock at %0t: got %b, expected at most one motor on the granted door",
               $time, outs());
    end
  end

  initial begin
    t_single[0] = '{1,  9'b10_00_0101_0, 8'b1000_01_1_0};
    t_single[1] = '{4,  9'b00_00_0001_0, 8'b1000_01_1_0};
    t_single[2] = '{1,  9'b00_00_1001_0, 8'b0000_01_1_0};
    t_single[3] = '{14, 9'b00_00_1001_0, 8'b0000_01_1_0};
    t_single[4] = '{1,  9'b00_00_1001_0, 8'b0100_01_1_0};
    t_single[5] = '{2,  9'b00_00_0001_0, 8'b0100_01_1_0};
    t_single[6] = '{1,  9'b00_00_0101_0, 8'b0000_00_1_0};
    t_single[7] = '{3,  9'b00_00_0101_0, 8'b0000_00_1_0};
    t_single[8] = '{1,  9'b00_00_0101_0, 8'b0000_00_0_0};

    t_tie[0]  = '{1,  9'b11_00_0101_0, 8'b1000_01_1_0};
    t_tie[1]  = '{3,  9'b00_00_0001_0, 8'b1000_01_1_0};
    t_tie[2]  = '{1,  9'b00_00_1001_0, 8'b0000_01_1_0};
    t_tie[3]  = '{15, 9'b00_00_1001_0, 8'b0100_01_1_0};
    t_tie[4]  = '{1,  9'b00_00_0001_0, 8'b0100_01_1_0};
    t_tie[5]  = '{1,  9'b00_00_0101_0, 8'b0000_00_1_0};
    t_tie[6]  = '{3,  9'b00_00_0101_0, 8'b0000_00_1_0};
    t_tie[7]  = '{1,  9'b00_00_0101_0, 8'b0000_00_0_0};
    t_tie[8]  = '{1,  9'b00_00_0101_0, 8'b0010_10_1_0};
    t_tie[9]  = '{2,  9'b00_00_0100_0, 8'b0010_10_1_0};
    t_tie[10] = '{1,  9'b00_00_0110_0, 8'b0000_10_1_0};
    t_tie[11] = '{15, 9'b00_00_0110_0, 8'b0001_10_1_0};
    t_tie[12] = '{1,  9'b00_00_0100_0, 8'b0001_10_1_0};
    t_tie[13] = '{1,  9'b00_00_0101_0, 8'b0000_00_1_0};
    t_tie[14] = '{3,  9'b00_00_0101_0, 8'b0000_00_1_0};
    t_tie[15] = '{1,  9'b11_00_0101_0, 8'b0000_00_0_0};
    t_tie[16] = '{1,  9'b00_00_0101_0, 8'b1000_01_1_0};

    drive(9'b00_00_0101_0);
    @(negedge clk);
    check("reset_initial", 8'b0000_00_0_0);
    rst = 1'b0;

    // Single request on A through a full cycle
    for (int i = 0; i < 9; i++) begin
      drive(t_single[i].in);
      step(t_single[i].rep);
      check($sformatf("single_%0d", i), t_single[i].exp);
    end

    // Tie, round robin, and a second tie latched during GAP
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(t_tie[i].in);
      step(t_tie[i].rep);
      check($sformatf("tie_%0d", i), t_tie[i].exp);
    end

    // Presence reload in HOLD at counter 3
    do_reset();
    drive(9'b10_00_0101_0); step(1);
    check("pr_grant", 8'b1000_01_1_0);
    drive(9'b00_00_0001_0); step(4);
    drive(9'b00_00_1001_0); step(1);
    step(11);
    check("pr_hold_cnt3", 8'b0000_01_1_0);
    drive(9'b00_10_1001_0); step(1);
    drive(9'b00_00_1001_0); step(14);
    check("pr_still_hold", 8'b0000_01_1_0);
    step(1);
    check("pr_close", 8'b0100_01_1_0);

    // Reopen on presence with closed switch, then async reset in CLOSE
    do_reset();
    drive(9'b01_00_0101_0); step(1);
    check("ro_grant_b", 8'b0010_10_1_0);
    drive(9'b00_00_0100_0); step(2);
    drive(9'b00_00_0110_0); step(1);
    check("ro_hold_b", 8'b0000_10_1_0);
    step(15);
    check("ro_close_b", 8'b0001_10_1_0);
    drive(9'b00_00_0100_0); step(1);
    check("ro_closing", 8'b0001_10_1_0);
    drive(9'b00_01_0101_0); step(1);
    check("ro_reopen", 8'b0010_10_1_0);
    drive(9'b00_00_0100_0); step(1);
    check("ro_reopening", 8'b0010_10_1_0);
    drive(9'b00_00_0110_0); step(16);
    check("ro_close_again", 8'b0001_10_1_0);
    drive(9'b10_00_0100_0); step(1);
    check("ro_req_a_queued", 8'b0001_10_1_0);
    drive(9'b00_00_0100_0);
    #2 rst = 1'b1;
    #1 check("ar_async_drop", 8'b0000_00_0_0);
    @(negedge clk);
    check("ar_reset_vals", 8'b0000_00_0_0);
    drive(9'b00_00_0101_0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("ar_pend_cleared", 8'b0000_00_0_0);

    // Watchdog fault in OPEN with B pending
    do_reset();
    drive(9'b11_00_0101_0); step(1);
    check("wd_grant_a", 8'b1000_01_1_0);
    drive(9'b00_00_0001_0); step(254);
    check("wd_open_255", 8'b1000_01_1_0);
    step(1);
    check("wd_fault", 8'b0000_00_1_1);
    drive(9'b00_00_0101_0); step(10);
    check("wd_fault_held", 8'b0000_00_1_1);
    drive(9'b00_00_0101_1); step(1);
    check("wd_clr", 8'b0000_00_0_0);
    drive(9'b00_00_0101_0); step(1);
    check("wd_grant_b", 8'b0010_10_1_0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
